// File: rtl/rx_frame_dispatch.sv
// Routes one received frame per popped header to the ARP port, the IPv4 port,
// or a drop sink, based on destination MAC filtering and ethertype.
module rx_frame_dispatch #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [47:0] FPGA_MAC   = 48'h00_18_3e_04_b3_f2,
  parameter logic [15:0] ARP_TYPE   = 16'h0806,
  parameter logic [15:0] IP_TYPE    = 16'h0800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  header_valid,
  input  logic [47:0]           dest_mac,
  input  logic [47:0]           src_mac,
  input  logic [15:0]           ethertype,
  output logic                  header_rd,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] a_axis_tdata,
  output logic                  a_axis_tvalid,
  output logic                  a_axis_tlast,
  input  logic                  a_axis_tready,
  output logic [DATA_WIDTH-1:0] b_axis_tdata,
  output logic                  b_axis_tvalid,
  output logic                  b_axis_tlast,
  input  logic                  b_axis_tready,
  output logic [47:0]           src_mac_q,
  output logic                  busy,
  output logic [15:0]           cnt_a,
  output logic [15:0]           cnt_b,
  output logic [15:0]           cnt_drop
);

  localparam int unsigned MAC_W = 48;
  localparam int unsigned CNT_W = 16;
  localparam logic [MAC_W-1:0] BCAST_MAC = '1;

  typedef enum logic [1:0] {IDLE, FWD_A, FWD_B, DROP} state_t;

  state_t state, state_next;
  logic   accept;
  logic   frame_end;

  assign accept = (dest_mac == FPGA_MAC) || (dest_mac == BCAST_MAC);

  // Data and last are passed through unqualified; only tvalid is gated.
  assign a_axis_tdata = s_axis_tdata;
  assign a_axis_tlast = s_axis_tlast;
  assign b_axis_tdata = s_axis_tdata;
  assign b_axis_tlast = s_axis_tlast;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    header_rd     = 1'b0;
    s_axis_tready = 1'b0;
    a_axis_tvalid = 1'b0;
    b_axis_tvalid = 1'b0;
    frame_end     = 1'b0;
    unique case (state)
      IDLE: begin
        // The header pop is suppressed while reset is held.
        if (header_valid && !rst) begin
          header_rd = 1'b1;
          if (accept && (ethertype == ARP_TYPE))     state_next = FWD_A;
          else if (accept && (ethertype == IP_TYPE)) state_next = FWD_B;
          else                                       state_next = DROP;
        end
      end
      FWD_A: begin
        a_axis_tvalid = s_axis_tvalid;
        s_axis_tready = a_axis_tready;
        frame_end     = s_axis_tvalid & a_axis_tready & s_axis_tlast;
        if (frame_end) state_next = IDLE;
      end
      FWD_B: begin
        b_axis_tvalid = s_axis_tvalid;
        s_axis_tready = b_axis_tready;
        frame_end     = s_axis_tvalid & b_axis_tready & s_axis_tlast;
        if (frame_end) state_next = IDLE;
      end
      DROP: begin
        s_axis_tready = 1'b1;
        frame_end     = s_axis_tvalid & s_axis_tlast;
        if (frame_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            src_mac_q <= '0;
    else if (header_rd) src_mac_q <= src_mac;
  end

  // Per-destination completed-frame counters, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a    <= '0;
      cnt_b    <= '0;
      cnt_drop <= '0;
    end else if (frame_end) begin
      unique case (state)
        FWD_A:   cnt_a    <= cnt_a + CNT_W'(1);
        FWD_B:   cnt_b    <= cnt_b + CNT_W'(1);
        DROP:    cnt_drop <= cnt_drop + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
